decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised successor to the combinational ID stage.
- Decodes operands and immediates, and detects hazards with a multi-cycle stall FSM.
- Resolves branches in ID, with branch-operand forwarding from MEM.
- Owns the ID/EX pipeline register; all EX-facing outputs are registered.
- Sits between IF/ID and EX. The register file and control decoder remain external.

Parameters:
- DATA_W, 32: datapath width.
- REG_AW, 5: register address width. Register 0 is hardwired zero and never forwarded or hazarded.
- CTRL_W, 9: width of the control bundle passed to EX.
- LD_BR_STALL, 2: bubbles inserted when a branch in ID depends on a load in EX. Allowed range 1..3.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_inst  in  32  instruction word
- id_pc_plus_4  in  DATA_W  PC+4 of the ID instruction
- ctrl_in  in  CTRL_W  raw control from the control decoder
- is_beq  in  1  ID instruction is beq
- is_bne  in  1  ID instruction is bne
- rf_ra1  out  REG_AW  register-file read address 1
- rf_ra2  out  REG_AW  register-file read address 2
- rf_rd1  in  DATA_W  register-file read data 1 (write-before-read file)
- rf_rd2  in  DATA_W  register-file read data 2 (write-before-read file)
- ex_mem_read  in  1  instruction in EX is a load
- ex_reg_wr  in  1  instruction in EX writes a register
- ex_dst  in  REG_AW  destination register of the EX instruction
- mem_reg_wr  in  1  MEM instruction writes a register
- mem_dst  in  REG_AW  destination register of the MEM instruction
- mem_result  in  DATA_W  forwardable MEM result
- flush  in  1  external flush (jump/exception)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID update enable
- ifid_flush  out  1  squash IF/ID
- branch_taken  out  1  branch taken this cycle
- branch_target  out  DATA_W  branch target address
- ex_valid  out  1  registered: ID/EX valid
- ex_ctrl  out  CTRL_W  registered: control bundle
- ex_data_a  out  DATA_W  registered: operand A
- ex_data_b  out  DATA_W  registered: operand B
- ex_imm  out  DATA_W  registered: immediate
- ex_rs  out  REG_AW  registered: rs field
- ex_rt  out  REG_AW  registered: rt field
- ex_rd  out  REG_AW  registered: rd field

Behaviour:
- Field decode:
  - rs = inst[25:21], rt = inst[20:16], rd = inst[15:11].
  - imm = inst[15:0] sign-extended to DATA_W.
  - branch_target = (imm << 2) + id_pc_plus_4, truncated to DATA_W.
- Shift (opcode 0 and funct 0):
  - rf_ra1 = rt, rf_ra2 = 0.
  - Operand B = shamt inst[10:6], zero-extended.
- Otherwise: rf_ra1 = rs, rf_ra2 = rt.
- Forwarding (applies to both the branch compare and the operands latched into ID/EX):
  - Operand n = mem_result if mem_reg_wr && mem_dst != 0 && mem_dst == rf_ran.
  - Otherwise operand n = rf_rdn.
- Hazard classes (evaluated only when id_valid; "match" means ex_dst != 0 and ex_dst equals rf_ra1 or rf_ra2):
  - LOADUSE: ex_mem_read && match. Needs 1 bubble.
  - BR_ALU: (is_beq | is_bne) && ex_reg_wr && !ex_mem_read && match. Needs 1 bubble.
  - BR_LOAD: (is_beq | is_bne) && ex_mem_read && match. Needs LD_BR_STALL bubbles; takes precedence over LOADUSE.
- FSM state RUN:
  - No hazard: pc_write = 1, ifid_write = 1.
  - ID/EX loads {id_valid, ctrl_in, operands, imm, fields}.
  - Hazard: pc_write = 0, ifid_write = 0, and ID/EX loads a bubble (ex_valid = 0, ex_ctrl = 0, data outputs hold).
  - On hazard, go to STALL with cnt = N-1 if N > 1; otherwise stay in RUN (the hazard is re-evaluated next cycle and has cleared).
- FSM state STALL:
  - pc_write = 0, ifid_write = 0, bubble into ID/EX.
  - Decrement cnt; when cnt == 0, return to RUN.
  - Hazards are not re-evaluated while in STALL.
- Branch resolution (RUN only, no hazard, id_valid):
  - eq = (operand A == operand B).
  - branch_taken = (is_beq & eq) | (is_bne & ~eq).
  - When taken, ifid_flush = 1 in the same cycle; the ID instruction itself still enters EX.
  - branch_taken = 0 in STALL, on a hazard, and when id_valid = 0.
- flush has highest priority:
  - ID/EX loads a bubble; the FSM is forced to RUN with cnt = 0.
  - pc_write = 1, ifid_write = 1, ifid_flush = 1, branch_taken = 0.
- Reset (asynchronous, reset_n = 0):
  - All registered outputs = 0; state = RUN; cnt = 0.
  - Combinational outputs follow with id_valid gating.
- Latency: ID/EX outputs are valid 1 cycle after the ID cycle. branch_taken and branch_target are combinational in the ID cycle.
- Reset asserted mid-STALL: all state is cleared. After release, the held instruction is re-evaluated from RUN.

Test Plan:
- lw $2 in EX (ex_mem_read = 1, ex_dst = 2); ID add $3,$2,$4 -> exactly 1 cycle with pc_write = 0 and ex_valid = 0, then add latched with ex_valid = 1.
- ID beq $2,$5 with load to $2 in EX, LD_BR_STALL = 2 -> 2 bubble cycles; then with mem_dst = 2 and mem_result = 7 matching rf_rd2 = 7: branch_taken = 1, ifid_flush = 1, branch_target = pc+4+(imm<<2).
- ID bne $1,$1, no hazards -> branch_taken = 0. Immediate 16'hFFFF with pc_plus_4 = 0x100 -> branch_target = 0xFC.
- sll $4,$6,3 -> rf_ra1 = 6, rf_ra2 = 0, ex_data_b = 3. ex_dst = 0 with ex_mem_read = 1 -> no stall.
- flush asserted during the second STALL cycle -> next cycle state RUN, ex_valid = 0, pc_write = 1.
- reset_n pulsed low asynchronously mid-stall -> all ex_* outputs immediately 0, FSM in RUN.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - ID stage: operand/immediate decode, MEM forwarding, branch resolution,
// multi-cycle hazard stall FSM and the registered ID/EX pipeline boundary.
module decode_stage_pipe #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int CTRL_W      = 9,
   parameter int LD_BR_STALL = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [31:0]       id_inst,
   input  logic [DATA_W-1:0] id_pc_plus_4,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic              is_beq,
   input  logic              is_bne,
   output logic [REG_AW-1:0] rf_ra1,
   output logic [REG_AW-1:0] rf_ra2,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   input  logic              ex_mem_read,
   input  logic              ex_reg_wr,
   input  logic [REG_AW-1:0] ex_dst,
   input  logic              mem_reg_wr,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              flush,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_target,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_data_a,
   output logic [DATA_W-1:0] ex_data_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [1:0]        cnt, cnt_n;

   logic [REG_AW-1:0] rs, rt, rd;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] shamt_ext;
   logic              is_shift;
   logic              is_branch;

   logic              fwd_a_sel, fwd_b_sel;
   logic [DATA_W-1:0] op_a, fwd_b, op_b;
   logic              operands_eq;

   logic              dst_match;
   logic              hz_br_load, hz_load_use, hz_br_alu, hazard;
   logic [1:0]        hz_bubbles;
   logic              load_bubble;

   // Field decode
   assign rs        = REG_AW'(id_inst[25:21]);
   assign rt        = REG_AW'(id_inst[20:16]);
   assign rd        = REG_AW'(id_inst[15:11]);
   assign imm       = {{(DATA_W-16){id_inst[15]}}, id_inst[15:0]};
   assign shamt_ext = {{(DATA_W-5){1'b0}}, id_inst[10:6]};
   assign is_shift  = (id_inst[31:26] == 6'd0) && (id_inst[5:0] == 6'd0);
   assign is_branch = is_beq | is_bne;

   assign branch_target = (imm << 2) + id_pc_plus_4;

   // Shifts read their source through port 1 and take operand B from shamt
   assign rf_ra1 = is_shift ? rt : rs;
   assign rf_ra2 = is_shift ? '0 : rt;

   assign fwd_a_sel   = mem_reg_wr && (mem_dst != '0) && (mem_dst == rf_ra1);
   assign fwd_b_sel   = mem_reg_wr && (mem_dst != '0) && (mem_dst == rf_ra2);
   assign op_a        = fwd_a_sel ? mem_result : rf_rd1;
   assign fwd_b       = fwd_b_sel ? mem_result : rf_rd2;
   assign op_b        = is_shift ? shamt_ext : fwd_b;
   assign operands_eq = (op_a == op_b);

   // Hazard classification; branch-on-load outranks plain load-use
   assign dst_match   = (ex_dst != '0) && ((ex_dst == rf_ra1) || (ex_dst == rf_ra2));
   assign hz_br_load  = id_valid && is_branch && ex_mem_read && dst_match;
   assign hz_load_use = id_valid && ex_mem_read && dst_match && !hz_br_load;
   assign hz_br_alu   = id_valid && is_branch && ex_reg_wr && !ex_mem_read && dst_match;
   assign hazard      = hz_br_load | hz_load_use | hz_br_alu;
   assign hz_bubbles  = hz_br_load ? 2'(LD_BR_STALL) : 2'd1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      branch_taken = 1'b0;
      load_bubble  = 1'b0;
      if (flush) begin
         state_n     = ST_RUN;
         cnt_n       = 2'd0;
         ifid_flush  = 1'b1;
         load_bubble = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (hazard) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  load_bubble = 1'b1;
                  if (hz_bubbles > 2'd1) begin
                     state_n = ST_STALL;
                     cnt_n   = hz_bubbles - 2'd1;
                  end
               end else if (id_valid) begin
                  branch_taken = (is_beq & operands_eq) | (is_bne & ~operands_eq);
                  ifid_flush   = branch_taken;
               end
            end
            ST_STALL: begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               load_bubble = 1'b1;
               if (cnt <= 2'd1) begin
                  state_n = ST_RUN;
                  cnt_n   = 2'd0;
               end else begin
                  cnt_n = cnt - 2'd1;
               end
            end
            default: begin
               state_n = ST_RUN;
               cnt_n   = 2'd0;
            end
         endcase
      end
   end

   // Bubbles clear valid/control only; data fields keep their last value
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid  <= 1'b0;
         ex_ctrl   <= '0;
         ex_data_a <= '0;
         ex_data_b <= '0;
         ex_imm    <= '0;
         ex_rs     <= '0;
         ex_rt     <= '0;
         ex_rd     <= '0;
      end else if (load_bubble) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
      end else begin
         ex_valid  <= id_valid;
         ex_ctrl   <= ctrl_in;
         ex_data_a <= op_a;
         ex_data_b <= op_b;
         ex_imm    <= imm;
         ex_rs     <= rs;
         ex_rt     <= rt;
         ex_rd     <= rd;
      end
   end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed bench for decode_stage_pipe with hand-computed expectations.
module tb_decode_stage_pipe;

   localparam int DATA_W      = 32;
   localparam int REG_AW      = 5;
   localparam int CTRL_W      = 9;
   localparam int LD_BR_STALL = 2;

   localparam logic [31:0] I_ADD = 32'h0044_1820;  // add $3,$2,$4
   localparam logic [31:0] I_BEQ = 32'h1045_0004;  // beq $2,$5,+4
   localparam logic [31:0] I_BNE = 32'h1421_FFFF;  // bne $1,$1,-1
   localparam logic [31:0] I_SLL = 32'h0006_20C0;  // sll $4,$6,3

   logic              clock = 1'b0;
   logic              reset_n;
   logic              id_valid;
   logic [31:0]       id_inst;
   logic [DATA_W-1:0] id_pc_plus_4;
   logic [CTRL_W-1:0] ctrl_in;
   logic              is_beq, is_bne;
   logic [REG_AW-1:0] rf_ra1, rf_ra2;
   logic [DATA_W-1:0] rf_rd1, rf_rd2;
   logic              ex_mem_read, ex_reg_wr;
   logic [REG_AW-1:0] ex_dst;
   logic              mem_reg_wr;
   logic [REG_AW-1:0] mem_dst;
   logic [DATA_W-1:0] mem_result;
   logic              flush;
   logic              pc_write, ifid_write, ifid_flush, branch_taken;
   logic [DATA_W-1:0] branch_target;
   logic              ex_valid;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [DATA_W-1:0] ex_data_a, ex_data_b, ex_imm;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   decode_stage_pipe #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .LD_BR_STALL(LD_BR_STALL)
   ) dut (
      .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_inst(id_inst),
      .id_pc_plus_4(id_pc_plus_4), .ctrl_in(ctrl_in), .is_beq(is_beq), .is_bne(is_bne),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .ex_mem_read(ex_mem_read), .ex_reg_wr(ex_reg_wr), .ex_dst(ex_dst),
      .mem_reg_wr(mem_reg_wr), .mem_dst(mem_dst), .mem_result(mem_result), .flush(flush),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_data_a(ex_data_a), .ex_data_b(ex_data_b),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_pipe();
      ex_mem_read = 1'b0;
      ex_reg_wr   = 1'b0;
      ex_dst      = '0;
      mem_reg_wr  = 1'b0;
      mem_dst     = '0;
      mem_result  = '0;
   endtask

   initial begin
      reset_n      = 1'b0;
      id_valid     = 1'b0;
      id_inst      = '0;
      id_pc_plus_4 = '0;
      ctrl_in      = '0;
      is_beq       = 1'b0;
      is_bne       = 1'b0;
      rf_rd1       = '0;
      rf_rd2       = '0;
      flush        = 1'b0;
      clear_pipe();

      // Reset state
      #12;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
      chk("rst_ex_data_a", ex_data_a, 32'd0);
      chk("rst_pc_write", 32'(pc_write), 32'd1);
      chk("rst_branch_taken", 32'(branch_taken), 32'd0);
      step();
      reset_n = 1'b1;

      // Load-use: lw $2 in EX, add $3,$2,$4 in ID
      id_valid    = 1'b1;
      id_inst     = I_ADD;
      ctrl_in     = 9'h1A5;
      rf_rd1      = 32'h11;
      rf_rd2      = 32'h22;
      ex_mem_read = 1'b1;
      ex_reg_wr   = 1'b1;
      ex_dst      = 5'd2;
      #1;
      chk("lu_ra1", 32'(rf_ra1), 32'd2);
      chk("lu_ra2", 32'(rf_ra2), 32'd4);
      chk("lu_pc_write", 32'(pc_write), 32'd0);
      chk("lu_ifid_write", 32'(ifid_write), 32'd0);
      step();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
      clear_pipe();
      mem_reg_wr = 1'b1;
      mem_dst    = 5'd2;
      mem_result = 32'h55;
      #1;
      chk("lu_resume_pc_write", 32'(pc_write), 32'd1);
      step();
      chk("lu_ex_valid", 32'(ex_valid), 32'd1);
      chk("lu_ex_ctrl", 32'(ex_ctrl), 32'h1A5);
      chk("lu_ex_data_a_fwd", ex_data_a, 32'h55);
      chk("lu_ex_data_b", ex_data_b, 32'h22);
      chk("lu_ex_imm", ex_imm, 32'h1820);
      chk("lu_ex_rs", 32'(ex_rs), 32'd2);
      chk("lu_ex_rt", 32'(ex_rt), 32'd4);
      chk("lu_ex_rd", 32'(ex_rd), 32'd3);

      // Branch on load: beq $2,$5 with load to $2 in EX, two bubbles
      clear_pipe();
      id_inst      = I_BEQ;
      is_beq       = 1'b1;
      id_pc_plus_4 = 32'h200;
      ctrl_in      = 9'h003;
      rf_rd1       = 32'h99;
      rf_rd2       = 32'h7;
      ex_mem_read  = 1'b1;
      ex_reg_wr    = 1'b1;
      ex_dst       = 5'd2;
      #1;
      chk("bl_c1_pc_write", 32'(pc_write), 32'd0);
      chk("bl_c1_taken", 32'(branch_taken), 32'd0);
      step();
      chk("bl_c1_ex_valid", 32'(ex_valid), 32'd0);
      clear_pipe();
      #1;
      chk("bl_c2_pc_write", 32'(pc_write), 32'd0);
      chk("bl_c2_taken", 32'(branch_taken), 32'd0);
      step();
      chk("bl_c2_ex_valid", 32'(ex_valid), 32'd0);
      mem_reg_wr = 1'b1;
      mem_dst    = 5'd2;
      mem_result = 32'h7;
      #1;
      chk("bl_run_pc_write", 32'(pc_write), 32'd1);
      chk("bl_taken", 32'(branch_taken), 32'd1);
      chk("bl_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("bl_target", branch_target, 32'h210);
      step();
      chk("bl_ex_valid", 32'(ex_valid), 32'd1);
      chk("bl_ex_data_a", ex_data_a, 32'h7);

      // bne $1,$1 with no hazard, negative immediate
      clear_pipe();
      is_beq       = 1'b0;
      is_bne       = 1'b1;
      id_inst      = I_BNE;
      id_pc_plus_4 = 32'h100;
      rf_rd1       = 32'h5;
      rf_rd2       = 32'h5;
      #1;
      chk("bne_eq_taken", 32'(branch_taken), 32'd0);
      chk("bne_eq_ifid_flush", 32'(ifid_flush), 32'd0);
      chk("bne_target", branch_target, 32'hFC);
      rf_rd2 = 32'h6;
      #1;
      chk("bne_ne_taken", 32'(branch_taken), 32'd1);
      step();

      // sll $4,$6,3 with a load to $0 in EX
      is_bne      = 1'b0;
      id_inst     = I_SLL;
      rf_rd1      = 32'h66;
      rf_rd2      = 32'hABC;
      ex_mem_read = 1'b1;
      ex_dst      = 5'd0;
      #1;
      chk("sll_ra1", 32'(rf_ra1), 32'd6);
      chk("sll_ra2", 32'(rf_ra2), 32'd0);
      chk("sll_no_stall", 32'(pc_write), 32'd1);
      step();
      chk("sll_ex_valid", 32'(ex_valid), 32'd1);
      chk("sll_ex_data_a", ex_data_a, 32'h66);
      chk("sll_ex_data_b", ex_data_b, 32'h3);

      // Flush during the second stall cycle
      clear_pipe();
      id_inst      = I_BEQ;
      is_beq       = 1'b1;
      id_pc_plus_4 = 32'h200;
      ex_mem_read  = 1'b1;
      ex_dst       = 5'd2;
      step();
      clear_pipe();
      flush = 1'b1;
      #1;
      chk("fl_pc_write", 32'(pc_write), 32'd1);
      chk("fl_ifid_write", 32'(ifid_write), 32'd1);
      chk("fl_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("fl_taken", 32'(branch_taken), 32'd0);
      step();
      flush  = 1'b0;
      rf_rd1 = 32'h1;
      rf_rd2 = 32'h1;
      #1;
      chk("fl_ex_valid", 32'(ex_valid), 32'd0);
      chk("fl_data_hold", ex_data_a, 32'h66);
      chk("fl_run_pc_write", 32'(pc_write), 32'd1);
      chk("fl_run_taken", 32'(branch_taken), 32'd1);
      step();
      chk("fl_after_data_a", ex_data_a, 32'h1);

      // Asynchronous reset in the middle of a stall
      ex_mem_read = 1'b1;
      ex_reg_wr   = 1'b1;
      ex_dst      = 5'd2;
      step();
      reset_n = 1'b0;
      #1;
      chk("ar_ex_valid", 32'(ex_valid), 32'd0);
      chk("ar_ex_data_a", ex_data_a, 32'd0);
      chk("ar_ex_data_b", ex_data_b, 32'd0);
      chk("ar_ex_imm", ex_imm, 32'd0);
      chk("ar_ex_rs", 32'(ex_rs), 32'd0);
      clear_pipe();
      #1;
      chk("ar_run_pc_write", 32'(pc_write), 32'd1);
      chk("ar_run_taken", 32'(branch_taken), 32'd1);
      step();
      reset_n     = 1'b1;
      ex_mem_read = 1'b1;
      ex_reg_wr   = 1'b1;
      ex_dst      = 5'd2;
      #1;
      chk("ar_reeval_pc_write", 32'(pc_write), 32'd0);
      step();
      clear_pipe();
      #1;
      chk("ar_stall_pc_write", 32'(pc_write), 32'd0);
      step();
      chk("ar_resume_pc_write", 32'(pc_write), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
